seven_segment_reader: RTL and testbench

- Receives a multiplexed seven-segment display bus: segment lines plus one-hot digit selects.
- Recovers the BCD value of every digit by inverting the standard 0–9 segment encoding.
- Assembles a full multi-digit frame and presents it on a valid/ready output.
- Sits at the receiving end of the display path; used for display loop-back checking and for reading seven-segment panels driven by other boards.

---
 rtl/seven_segment_reader.sv | 183 ++++++++++++++++++
 tb/tb_seven_segment_reader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_reader.sv
// seven_segment_reader: recovers BCD digits from a multiplexed seven-segment
// bus (segments + one-hot digit selects) and presents whole frames on a
// valid/ready output.
// Optional feature: define SEVEN_SEGMENT_READER_HEX_EN to also decode A-F glyphs.
module seven_segment_reader #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank_out,
  output logic [DIGITS-1:0]     err_out,
  output logic                  overrun,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

  // Glyph decode, result is {err, blank, value}
  function automatic logic [5:0] decode(input logic [6:0] p);
    logic [5:0] r;
    case (p)
      7'h7E:   r = {2'b00, 4'h0};
      7'h30:   r = {2'b00, 4'h1};
      7'h6D:   r = {2'b00, 4'h2};
      7'h79:   r = {2'b00, 4'h3};
      7'h33:   r = {2'b00, 4'h4};
      7'h5B:   r = {2'b00, 4'h5};
      7'h5F:   r = {2'b00, 4'h6};
      7'h70:   r = {2'b00, 4'h7};
      7'h7F:   r = {2'b00, 4'h8};
      7'h7B:   r = {2'b00, 4'h9};
      7'h00:   r = {2'b01, 4'h0};
`ifdef SEVEN_SEGMENT_READER_HEX_EN
      7'h77:   r = {2'b00, 4'hA};
      7'h1F:   r = {2'b00, 4'hB};
      7'h4E:   r = {2'b00, 4'hC};
      7'h3D:   r = {2'b00, 4'hD};
      7'h4F:   r = {2'b00, 4'hE};
      7'h47:   r = {2'b00, 4'hF};
`endif
      default: r = {2'b10, 4'hF};
    endcase
    return r;
  endfunction

  logic [6:0]          seg_sync_q, seg_sync_d, seg_prev_q, seg_prev_d;
  logic [DIGITS-1:0]   an_sync_q, an_sync_d, an_prev_q, an_prev_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                captured_q, captured_d;
  logic [4*DIGITS-1:0] stage_bcd_q, stage_bcd_d;
  logic [DIGITS-1:0]   stage_blank_q, stage_blank_d;
  logic [DIGITS-1:0]   stage_err_q, stage_err_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [DIGITS-1:0]   err_q, err_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;

  logic                changed, one_hot, capture, complete;
  logic [5:0]          dec;
  logic [DIGITS-1:0]   seen_next;

  // Stability tracking, digit capture, frame assembly and output handshake
  always_comb begin
    seg_sync_d    = seg;
    an_sync_d     = an;
    seg_prev_d    = seg_sync_q;
    an_prev_d     = an_sync_q;
    cnt_d         = cnt_q;
    captured_d    = captured_q;
    stage_bcd_d   = stage_bcd_q;
    stage_blank_d = stage_blank_q;
    stage_err_d   = stage_err_q;
    seen_d        = seen_q;
    bcd_d         = bcd_q;
    blank_d       = blank_q;
    err_d         = err_q;
    valid_d       = valid_q;
    overrun_d     = overrun_q;
    seen_next     = seen_q;
    complete      = 1'b0;

    changed = ({seg_sync_q, an_sync_q} != {seg_prev_q, an_prev_q});
    one_hot = (an_sync_q != '0) &&
              ((an_sync_q & (an_sync_q - DIGITS'(1))) == '0);
    dec     = decode(seg_sync_q);

    if (changed) begin
      cnt_d = '0;
    end else if (cnt_q < CW'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + CW'(1);
    end

    // One capture per dwell; only a change on the bus re-arms it
    capture = !changed && (cnt_d == CW'(STABLE_CYCLES - 1)) && !captured_q && one_hot;
    if (changed) begin
      captured_d = 1'b0;
    end else if (capture) begin
      captured_d = 1'b1;
    end

    if (capture) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (an_sync_q[i]) begin
          stage_bcd_d[4*i +: 4] = dec[3:0];
          stage_blank_d[i]      = dec[4];
          stage_err_d[i]        = dec[5];
        end
      end
      seen_next = seen_q | an_sync_q;
      seen_d    = seen_next;
      complete  = (seen_next == {DIGITS{1'b1}});
    end

    if (valid_q && out_ready) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    // A finished frame loads unless the previous one is still pending
    if (complete) begin
      seen_d = '0;
      if (!valid_q || out_ready) begin
        bcd_d   = stage_bcd_d;
        blank_d = stage_blank_d;
        err_d   = stage_err_d;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_sync_q    <= '0;
      an_sync_q     <= '0;
      seg_prev_q    <= '0;
      an_prev_q     <= '0;
      cnt_q         <= '0;
      captured_q    <= 1'b0;
      stage_bcd_q   <= '0;
      stage_blank_q <= '0;
      stage_err_q   <= '0;
      seen_q        <= '0;
      bcd_q         <= '0;
      blank_q       <= '0;
      err_q         <= '0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      seg_sync_q    <= seg_sync_d;
      an_sync_q     <= an_sync_d;
      seg_prev_q    <= seg_prev_d;
      an_prev_q     <= an_prev_d;
      cnt_q         <= cnt_d;
      captured_q    <= captured_d;
      stage_bcd_q   <= stage_bcd_d;
      stage_blank_q <= stage_blank_d;
      stage_err_q   <= stage_err_d;
      seen_q        <= seen_d;
      bcd_q         <= bcd_d;
      blank_q       <= blank_d;
      err_q         <= err_d;
      valid_q       <= valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bcd_out   = bcd_q;
  assign blank_out = blank_q;
  assign err_out   = err_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Testbench for seven_segment_reader (DIGITS=4, STABLE_CYCLES=4): directed
// scenarios followed by randomized dwells, checked against a frame-level model.
module tb_seven_segment_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] bcd_out;
  logic [3:0]  blank_out, err_out;
  logic        overrun, out_valid, out_ready;

  always #5 clk = ~clk;

  seven_segment_reader #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an),
    .bcd_out(bcd_out), .blank_out(blank_out), .err_out(err_out),
    .overrun(overrun), .out_valid(out_valid), .out_ready(out_ready)
  );

  int n_pass  = 0;
  int n_total = 0;

`ifdef SEVEN_SEGMENT_READER_HEX_EN
  localparam int NPAT = 16;
`else
  localparam int NPAT = 10;
`endif
  logic [6:0] pat [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Reference state: staged digits, seen slots, and the presented frame
  logic [3:0]  st_val [4];
  logic [3:0]  st_blk, st_err, seen;
  logic [15:0] exp_bcd;
  logic [3:0]  exp_blank, exp_err;
  logic        exp_valid, exp_ovr;

  function automatic void ref_decode(input logic [6:0] p, output logic [3:0] v,
                                     output logic b, output logic e);
    v = 4'hF; b = 1'b0; e = 1'b1;
    if (p == 7'h00) begin
      v = 4'h0; e = 1'b0; b = 1'b1;
    end
    for (int k = 0; k < NPAT; k++)
      if (pat[k] == p) begin
        v = 4'(k); e = 1'b0;
      end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) st_val[i] = 4'h0;
    st_blk = '0; st_err = '0; seen = '0;
    exp_bcd = '0; exp_blank = '0; exp_err = '0; exp_valid = 1'b0; exp_ovr = 1'b0;
  endtask

  // One digit captured; rdy says whether the consumer was ready on that edge
  task automatic model_capture(input logic [6:0] s, input logic [3:0] a, input logic rdy);
    logic [3:0] v;
    logic b, e;
    int slot;
    slot = 0;
    for (int i = 0; i < 4; i++) if (a[i]) slot = i;
    ref_decode(s, v, b, e);
    st_val[slot] = v; st_blk[slot] = b; st_err[slot] = e;
    seen[slot] = 1'b1;
    if (rdy && exp_valid) begin
      exp_valid = 1'b0; exp_ovr = 1'b0;
    end
    if (seen == 4'hF) begin
      seen = '0;
      if (exp_valid) exp_ovr = 1'b1;
      else begin
        exp_bcd   = {st_val[3], st_val[2], st_val[1], st_val[0]};
        exp_blank = st_blk;
        exp_err   = st_err;
        exp_valid = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".bcd"},     32'(bcd_out),   32'(exp_bcd));
    check({tag, ".blank"},   32'(blank_out), 32'(exp_blank));
    check({tag, ".err"},     32'(err_out),   32'(exp_err));
    check({tag, ".valid"},   32'(out_valid), 32'(exp_valid));
    check({tag, ".overrun"}, 32'(overrun),   32'(exp_ovr));
  endtask

  // Present {s,a} for len rising edges, ending 1 time unit after the last
  task automatic drive(input logic [6:0] s, input logic [3:0] a, input int len);
    @(negedge clk);
    seg = s; an = a;
    repeat (len) @(posedge clk);
    #1;
  endtask

  // Gap, then a dwell; long one-hot dwells capture, short ones never do
  task automatic dwell(input string tag, input logic [6:0] s, input logic [3:0] a, input int len);
    drive(7'h00, 4'h0, 1);
    drive(s, a, len);
    if (len >= 5 && $countones(a) == 1) model_capture(s, a, 1'b0);
    check_all(tag);
  endtask

  task automatic accept(input string tag);
    @(negedge clk);
    seg = 7'h00; an = 4'h0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    if (exp_valid) begin
      exp_valid = 1'b0; exp_ovr = 1'b0;
    end
    check_all(tag);
  endtask

  function automatic logic [6:0] rseg();
    int r;
    r = int'($urandom_range(0, 17));
    if (r < 16) return pat[r];
    if (r == 16) return 7'h00;
    return 7'($urandom);
  endfunction

  task automatic rand_frame(input string tag);
    for (int i = 0; i < 4; i++) dwell(tag, rseg(), 4'(1 << i), int'($urandom_range(5, 9)));
  endtask

  initial begin
    seg = '0; an = '0; out_ready = 1'b0; rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("reset");

    // Too-short dwell on digit 0 must not capture
    dwell("glitch3", 7'h30, 4'b0001, 3);

    // Full frame 4321 with latency observed on the last digit
    dwell("f1.d0", 7'h30, 4'b0001, 8);
    dwell("f1.d1", 7'h6D, 4'b0010, 8);
    dwell("f1.d2", 7'h79, 4'b0100, 8);
    drive(7'h00, 4'h0, 1);
    drive(7'h33, 4'b1000, 4);
    check_all("f1.pre_latency");
    drive(7'h33, 4'b1000, 1);
    model_capture(7'h33, 4'b1000, 1'b0);
    check_all("f1.latency");
    check("f1.value", 32'(bcd_out), 32'h4321);
    accept("f1.accept");

    // Blank, undecodable and hex glyphs
    dwell("f2.d0", 7'h7E, 4'b0001, 6);
    dwell("f2.d1", 7'h01, 4'b0010, 6);
    dwell("f2.d2", 7'h00, 4'b0100, 6);
    dwell("f2.d3", 7'h77, 4'b1000, 6);
    check("f2.blank_const", 32'(blank_out), 32'h4);
    check("f2.err1", 32'(err_out[1]), 32'h1);
    accept("f2.accept");

    // Back-pressure across two frames
    rand_frame("bp.f1");
    rand_frame("bp.f2");
    accept("bp.accept");

    // Select faults and recapture
    dwell("sel.multi", 7'h30, 4'b0011, 20);
    dwell("sel.zero",  7'h30, 4'b0000, 20);
    dwell("rc.d0",  7'h7E, 4'b0001, 6);
    dwell("rc.d1",  7'h30, 4'b0010, 6);
    dwell("rc.d0b", 7'h5B, 4'b0001, 6);
    dwell("rc.d2",  7'h79, 4'b0100, 6);
    dwell("rc.d3",  7'h33, 4'b1000, 6);
    check("rc.slot0", 32'(bcd_out[3:0]), 32'h5);
    accept("rc.accept");

    // Transfer and completion on the same edge while overrun is pending
    rand_frame("se.a");
    rand_frame("se.b");
    dwell("se.c0", 7'h5F, 4'b0001, 6);
    dwell("se.c1", 7'h70, 4'b0010, 6);
    dwell("se.c2", 7'h7F, 4'b0100, 6);
    drive(7'h00, 4'h0, 1);
    drive(7'h7B, 4'b1000, 4);
    check_all("se.pre");
    out_ready = 1'b1;
    drive(7'h7B, 4'b1000, 1);
    out_ready = 1'b0;
    model_capture(7'h7B, 4'b1000, 1'b1);
    check_all("se.same_edge");
    accept("se.accept");

    // Mid-frame reset discards the partial frame
    dwell("mr.d0", 7'h30, 4'b0001, 6);
    dwell("mr.d1", 7'h30, 4'b0010, 6);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all("mr.in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    rand_frame("mr.new");
    accept("mr.accept");

    // Randomized dwells, glitches, bad selects and accepts
    for (int n = 0; n < 80; n++) begin
      int kind;
      logic [3:0] a;
      kind = int'($urandom_range(0, 19));
      if (kind < 14) begin
        dwell("rnd.cap", rseg(), 4'(1 << $urandom_range(0, 3)), int'($urandom_range(5, 9)));
      end else if (kind < 17) begin
        dwell("rnd.glitch", rseg(), 4'(1 << $urandom_range(0, 3)), int'($urandom_range(1, 3)));
      end else begin
        a = 4'($urandom);
        if ($countones(a) == 1) a = a | 4'(1 << $urandom_range(0, 3)) | 4'b0001 | 4'b1000;
        dwell("rnd.badsel", rseg(), a, int'($urandom_range(5, 12)));
      end
      if ($urandom_range(0, 9) < 3) accept("rnd.accept");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
